// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the single-precision post-adder
// normalise/round stage.
package fp_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] EXP_MAX    = 8'hFF;
    localparam int         BIAS       = 127;
    localparam int         CARRY_BIT  = 25;
    localparam int         HIDDEN_BIT = 24;
    localparam int         GUARD_BIT  = 0;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa; the increment ripples
// through a chain of full-adder cells.
module fp_round_rne
    import fp_norm_pkg::*;
#(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+2:0] m,
    input  logic             s,
    output logic [MAN_W-1:0] frac,
    output logic             exp_inc
);

    logic             inc;
    logic [MAN_W+1:0] t;
    logic [MAN_W+2:0] c;
    logic [1:0]       fa_out [MAN_W+2];

    assign inc  = m[GUARD_BIT] & (s | m[GUARD_BIT+1]);
    assign c[0] = inc;

    for (genvar i = 0; i < MAN_W + 2; i++) begin : g_inc
        assign fa_out[i] = full_add(m[i+1], 1'b0, c[i]);
        assign t[i]      = fa_out[i][0];
        assign c[i+1]    = fa_out[i][1];
    end

    // A carry into the hidden-bit-plus-one position means 1.11..1 rolled to 10.0..0.
    assign exp_inc = t[MAN_W+1];
    assign frac    = exp_inc ? {MAN_W{1'b0}} : t[MAN_W-1:0];

endmodule

// File: rtl/fp_norm_round.sv
// Post-adder stage: iterative one-bit-per-cycle normalisation, RNE rounding
// and IEEE-754 single packing behind valid/ready handshakes.
module fp_norm_round
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MAN_W+2:0]       in_sum,
    input  logic                   in_sticky,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic                   in_sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_ovf,
    output logic                   out_unf,
    output logic                   out_zero
);

    state_t                 state_q, state_d;
    logic [MAN_W+2:0]       m_q, m_d;
    logic                   s_q, s_d;
    logic [EXP_W:0]         e_q, e_d;
    logic                   sign_q, sign_d;
    logic [EXP_W+MAN_W:0]   res_q, res_d;
    logic                   ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic [MAN_W-1:0]       rnd_frac;
    logic                   rnd_exp_inc;
    logic [EXP_W:0]         e_fin;

    fp_round_rne #(.MAN_W(MAN_W)) u_round (
        .m       (m_q),
        .s       (s_q),
        .frac    (rnd_frac),
        .exp_inc (rnd_exp_inc)
    );

    assign e_fin = e_q + {{EXP_W{1'b0}}, rnd_exp_inc};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        s_d      = s_q;
        e_d      = e_q;
        sign_d   = sign_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = in_sum;
                    s_d     = in_sticky;
                    e_d     = {1'b0, in_exp};
                    sign_d  = in_sign;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (m_q == '0) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else if (m_q[CARRY_BIT]) begin
                    m_d     = m_q >> 1;
                    s_d     = s_q | m_q[0];
                    e_d     = e_q + {{EXP_W{1'b0}}, 1'b1};
                    state_d = ROUND;
                end else if (m_q[HIDDEN_BIT]) begin
                    state_d = ROUND;
                end else if (e_q == {{EXP_W{1'b0}}, 1'b1}) begin
                    res_d   = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    m_d     = m_q << 1;
                    e_d     = e_q - {{EXP_W{1'b0}}, 1'b1};
                    state_d = NORM;
                end
            end
            ROUND: begin
                if (e_fin >= {1'b0, EXP_MAX}) begin
                    res_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
                    ovf_d = 1'b1;
                end else begin
                    res_d = {sign_q, e_fin[EXP_W-1:0], rnd_frac};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Valid rises the cycle after DONE is entered, giving the documented latencies.
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            s_q         <= 1'b0;
            e_q         <= '0;
            sign_q      <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            e_q         <= e_d;
            sign_q      <= sign_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_zero   = zero_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed self-checking bench for fp_norm_round with hand-computed vectors.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] in_sum = 26'd0;
    logic        in_sticky = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_zero;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_sticky  (in_sticky),
        .in_exp     (in_exp),
        .in_sign    (in_sign),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_zero   (out_zero)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    // Offer one operation, measure latency, check result and flags, then consume it.
    task automatic run_op(input string tag, input logic [25:0] sum, input logic st,
                          input logic [7:0] ex, input logic sg, input logic [31:0] exp_res,
                          input logic [2:0] exp_flags, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        check_eq({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_sum = sum; in_sticky = st; in_exp = ex; in_sign = sg;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, {32'd0, out_result}, {32'd0, exp_res});
        check_eq({tag, "_flg"}, {61'd0, out_ovf, out_unf, out_zero}, {61'd0, exp_flags});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, "_vld0"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        int spurious;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdy", {63'd0, in_ready}, 64'd1);
        check_eq("rst_vld", {63'd0, out_valid}, 64'd0);
        check_eq("rst_res", {32'd0, out_result}, 64'd0);
        check_eq("rst_flg", {61'd0, out_ovf, out_unf, out_zero}, 64'd0);
        rst_n = 1'b1;

        run_op("one",    26'h1000000, 1'b0, 8'd127, 1'b0, 32'h3F800000, 3'b000, 3);
        run_op("carry",  26'h2000000, 1'b0, 8'd127, 1'b0, 32'h40000000, 3'b000, 3);
        run_op("lshift", 26'h0000002, 1'b0, 8'd127, 1'b0, 32'h34000000, 3'b000, 26);
        run_op("unf",    26'h0800000, 1'b0, 8'd1,   1'b1, 32'h80000000, 3'b010, 2);
        run_op("tie_ev", 26'h1000001, 1'b0, 8'd127, 1'b0, 32'h3F800000, 3'b000, 3);
        // Guard=1 with odd lsb ties up to the even neighbour: fraction 1 -> 2.
        run_op("tie_od", 26'h1000003, 1'b0, 8'd127, 1'b0, 32'h3F800002, 3'b000, 3);
        run_op("stky",   26'h1000001, 1'b1, 8'd127, 1'b0, 32'h3F800001, 3'b000, 3);
        run_op("rcarry", 26'h1FFFFFF, 1'b0, 8'd127, 1'b0, 32'h40000000, 3'b000, 3);
        run_op("ovf",    26'h3FFFFFF, 1'b0, 8'd254, 1'b0, 32'h7F800000, 3'b100, 3);
        run_op("zero",   26'h0000000, 1'b0, 8'd100, 1'b1, 32'h00000000, 3'b001, 2);

        // Backpressure: result held, second offer ignored.
        @(posedge clk); #1;
        in_valid = 1'b1; in_sum = 26'h1000000; in_sticky = 1'b0; in_exp = 8'd127; in_sign = 1'b1;
        @(posedge clk); #1;
        in_sum = 26'h2000000; in_sign = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_lat", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {29'd0, out_valid, in_ready, out_ovf, out_unf, out_zero, out_result},
                     {29'd0, 1'b1, 1'b0, 3'b000, 32'hBF800000});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check_eq("bp_noacc", 64'(spurious), 64'd0);

        // Reset while a long shift is in progress.
        @(posedge clk); #1;
        in_valid = 1'b1; in_sum = 26'h0000002; in_exp = 8'd127; in_sign = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mrst_rdy", {63'd0, in_ready}, 64'd1);
        check_eq("mrst_vld", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check_eq("mrst_quiet", 64'(spurious), 64'd0);
        run_op("post", 26'h1000000, 1'b0, 8'd128, 1'b0, 32'h40000000, 3'b000, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
